jborrowskip_subtractor_seq: RTL and testbench

//   Multi-cycle 8-bit borrow-skip subtractor: D = A - B - borrowin, the inverse operation
//   of the carry-skip adder in the FPGA arithmetic lab set.

---
 rtl/jborrowskip_subtractor_seq.sv | 140 ++++++++++++++
 tb/tb_jborrowskip_subtractor_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/jborrowskip_subtractor_seq.sv
// Multi-cycle borrow-skip subtractor: Y = A - B - borrowin, one BLOCK-bit slice per clock.
// Ports: clk, reset (sync, active-high); in_valid/in_ready + A, B, borrowin in;
//        out_valid/out_ready + Y, borrowout, skip_count out.
module jborrowskip_subtractor_seq #(
  parameter int WIDTH = 8,
  parameter int BLOCK = 4,
  localparam int NBLK = WIDTH / BLOCK,
  localparam int SCW  = $clog2(NBLK + 1),
  localparam int IW   = (NBLK > 1) ? $clog2(NBLK) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             borrowin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             borrowout,
  output logic [SCW-1:0]   skip_count
);

  if (WIDTH % BLOCK != 0) begin : g_chk
    $error("WIDTH must be a multiple of BLOCK");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             bor_q, bor_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             bo_q, bo_d;
  logic [SCW-1:0]   sc_q, sc_d;

  logic [BLOCK-1:0] s_a, s_b, s_d;
  logic             s_rb, s_skip, s_bout;
  logic             accept, last;

  // Current slice: explicit ripple chain plus the skip
  // bypass taken when every bit pair is equal (a-b == 0).
  always_comb begin
    s_a  = a_q[idx_q*BLOCK +: BLOCK];
    s_b  = b_q[idx_q*BLOCK +: BLOCK];
    s_d  = '0;
    s_rb = bor_q;
    for (int i = 0; i < BLOCK; i++) begin
      s_d[i] = s_a[i] ^ s_b[i] ^ s_rb;
      s_rb   = (~s_a[i] & s_b[i])
             | (~(s_a[i] ^ s_b[i]) & s_rb);
    end
    s_skip = &(~(s_a ^ s_b));
    s_bout = s_skip ? bor_q : s_rb;
  end

  assign last = (idx_q == IW'(NBLK - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    bor_d   = bor_q;
    y_d     = y_q;
    bo_d    = bo_q;
    sc_d    = sc_q;

    out_valid = (state_q == S_DONE);
    in_ready  = (state_q == S_IDLE)
              | ((state_q == S_DONE) & out_ready);
    accept    = in_valid & in_ready;

    unique case (state_q)
      S_IDLE: ;
      S_CALC: begin
        y_d[idx_q*BLOCK +: BLOCK] = s_d;
        bor_d = s_bout;
        if (s_skip) sc_d = sc_q + SCW'(1);
        if (last) begin
          bo_d    = s_bout;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Acceptance (IDLE, or DONE with the result taken)
    // overrides the hold/return-to-idle above.
    if (accept) begin
      a_d     = A;
      b_d     = B;
      bor_d   = borrowin;
      idx_d   = '0;
      y_d     = '0;
      bo_d    = 1'b0;
      sc_d    = '0;
      state_d = S_CALC;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      bor_q   <= 1'b0;
      y_q     <= '0;
      bo_q    <= 1'b0;
      sc_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      bor_q   <= bor_d;
      y_q     <= y_d;
      bo_q    <= bo_d;
      sc_q    <= sc_d;
    end
  end

  assign Y          = y_q;
  assign borrowout  = bo_q;
  assign skip_count = sc_q;

endmodule

// File: tb/tb_jborrowskip_subtractor_seq.sv
// Scoreboard bench for jborrowskip_subtractor_seq (8-bit, 4-bit slices).
// Random and directed operations against an arithmetic reference model.
module tb_jborrowskip_subtractor_seq;

  localparam int NBLK = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] A, B;
  logic       borrowin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] Y;
  logic       borrowout;
  logic [1:0] skip_count;

  jborrowskip_subtractor_seq #(
    .WIDTH(8),
    .BLOCK(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .borrowin  (borrowin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y),
    .borrowout (borrowout),
    .skip_count(skip_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] y;
    logic       bo;
    logic [1:0] sc;
    int         acc;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   rnd_rdy = 0;
  bit   seen = 0;
  logic acc_ov;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [7:0] a,
                                 input logic [7:0] b,
                                 input logic bin);
    exp_t e;
    int   d;
    d    = int'(a) - int'(b) - int'(bin);
    e.y  = d[7:0];
    e.bo = (d < 0);
    e.sc = 0;
    for (int k = 0; k < NBLK; k++)
      if (a[k*4 +: 4] == b[k*4 +: 4]) e.sc = e.sc + 2'd1;
    e.acc = 0;
    return e;
  endfunction

  task automatic send(input logic [7:0] a,
                      input logic [7:0] b,
                      input logic bin);
    exp_t e;
    int   n;
    A = a; B = b; borrowin = bin; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout a=%0d b=%0d", a, b);
      in_valid = 1'b0;
      return;
    end
    acc_ov = out_valid;
    e = model(a, b, bin);
    e.acc = cyc + 1;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = 8'($urandom); B = 8'($urandom); borrowin = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout pending=%0d", sbq.size());
      sbq.delete();
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: compares whatever the DUT presents against the queue head,
  // every cycle out_valid is high (so backpressure stability is checked).
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (out_valid) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_result y=%0d bo=%0d", Y, borrowout);
      end else begin
        e = sbq[0];
        if (!seen) begin
          total++;
          if (cyc - e.acc != NBLK) begin
            bad++;
            $display("FAIL latency got=%0d want=%0d", cyc - e.acc, NBLK);
          end
          seen = 1;
        end
        total++;
        if (Y !== e.y || borrowout !== e.bo || skip_count !== e.sc) begin
          bad++;
          $display("FAIL result y=%0d bo=%0d sc=%0d want y=%0d bo=%0d sc=%0d",
                   Y, borrowout, skip_count, e.y, e.bo, e.sc);
        end
        if (out_ready) begin
          void'(sbq.pop_front());
          seen = 0;
        end
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; borrowin = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_hs in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    total++;
    if (Y !== 8'd0 || borrowout !== 1'b0 || skip_count !== 2'd0) begin
      bad++;
      $display("FAIL reset_out y=%0d bo=%b sc=%0d want 0 0 0", Y, borrowout, skip_count);
    end

    @(posedge clk); #1;
    out_ready = 1'b1;
    send(8'd0, 8'd0, 1'b0);
    send(8'd3, 8'd2, 1'b1);
    send(8'd7, 8'd10, 1'b0);
    send(8'd15, 8'd15, 1'b1);
    send(8'd0, 8'd255, 1'b1);
    total++;
    if (acc_ov !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept out_valid_at_accept=%b want 1", acc_ov);
    end
    drain();

    // Backpressure: hold result for 5 cycles.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(8'd255, 8'd55, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (5) begin
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL backpressure in_ready=%b out_valid=%b want 0 1", in_ready, out_valid);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // Reset mid-CALC aborts the operation.
    @(posedge clk); #1;
    send(8'd100, 8'd1, 1'b0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    void'(sbq.pop_back());
    repeat (4) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || Y !== 8'd0) begin
        bad++;
        $display("FAIL reset_abort out_valid=%b in_ready=%b y=%0d want 0 1 0",
                 out_valid, in_ready, Y);
      end
    end

    @(posedge clk); #1;
    rnd_rdy = 1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      send(8'($urandom), 8'($urandom), 1'($urandom));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
